// File: rtl/click_sync_merge.sv
// Merges two granted two-phase click channels into one clocked valid/ready stream via a tagged FIFO.
// Optional per-channel and full-stall statistics counters are enabled with CLICK_SYNC_MERGE_STATS_EN.
module click_sync_merge #(
  parameter int DATA_W           = 8,
  parameter int DEPTH            = 4,
  parameter int SYNC_STAGES      = 2,
  parameter bit PHASE_INIT_ACK_A = 1'b0,
  parameter bit PHASE_INIT_ACK_B = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_a_req,
  output logic              in_a_ack,
  input  logic [DATA_W-1:0] in_a_data,
  input  logic              in_b_req,
  output logic              in_b_ack,
  input  logic [DATA_W-1:0] in_b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src
`ifdef CLICK_SYNC_MERGE_STATS_EN
  ,
  output logic [15:0]       stat_a_cnt,
  output logic [15:0]       stat_b_cnt,
  output logic [15:0]       stat_full_cyc
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [DATA_W-1:0]      mem_data [DEPTH];
  logic                   mem_src  [DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic [CW-1:0]          count;
  logic                   rr;
  logic                   pend_a, pend_b, pop, acc_a, acc_b, rr_flip;
  int                     room;

  // Stage: req synchronisers, reset to the ack phase so no token appears pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= {SYNC_STAGES{PHASE_INIT_ACK_A}};
      sync_b <= {SYNC_STAGES{PHASE_INIT_ACK_B}};
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], in_a_req};
      sync_b <= {sync_b[SYNC_STAGES-2:0], in_b_req};
    end
  end

  // Stage: accept decision; a same-edge pop frees one slot for the incoming token
  always_comb begin
    pend_a  = sync_a[SYNC_STAGES-1] ^ in_a_ack;
    pend_b  = sync_b[SYNC_STAGES-1] ^ in_b_ack;
    pop     = out_valid & out_ready;
    room    = DEPTH - int'(count) + int'(pop);
    acc_a   = 1'b0;
    acc_b   = 1'b0;
    rr_flip = 1'b0;
    if (pend_a && pend_b) begin
      if (room >= 2) begin
        acc_a = 1'b1;
        acc_b = 1'b1;
      end else if (room == 1) begin
        acc_a   = ~rr;
        acc_b   = rr;
        rr_flip = 1'b1;
      end
    end else if (pend_a && room >= 1) begin
      acc_a = 1'b1;
    end else if (pend_b && room >= 1) begin
      acc_b = 1'b1;
    end
  end

  // Stage: control state (acks, pointers, occupancy, round-robin)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_a_ack <= PHASE_INIT_ACK_A;
      in_b_ack <= PHASE_INIT_ACK_B;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rr       <= 1'b0;
    end else begin
      in_a_ack <= in_a_ack ^ acc_a;
      in_b_ack <= in_b_ack ^ acc_b;
      wptr     <= wptr + AW'(acc_a) + AW'(acc_b);
      rptr     <= rptr + AW'(pop);
      count    <= count + CW'(acc_a) + CW'(acc_b) - CW'(pop);
      if (rr_flip) rr <= ~rr;
    end
  end

  // Stage: FIFO storage; A lands first so it sits closer to the head
  always_ff @(posedge clk) begin
    if (acc_a) begin
      mem_data[wptr] <= in_a_data;
      mem_src[wptr]  <= 1'b0;
    end
    if (acc_b) begin
      mem_data[wptr + AW'(acc_a)] <= in_b_data;
      mem_src[wptr + AW'(acc_a)]  <= 1'b1;
    end
  end

  always_comb begin
    out_valid = (count != '0);
    out_data  = out_valid ? mem_data[rptr] : '0;
    out_src   = out_valid ? mem_src[rptr] : 1'b0;
  end

`ifdef CLICK_SYNC_MERGE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_a_cnt    <= '0;
      stat_b_cnt    <= '0;
      stat_full_cyc <= '0;
    end else begin
      stat_a_cnt    <= sat_inc(stat_a_cnt, acc_a);
      stat_b_cnt    <= sat_inc(stat_b_cnt, acc_b);
      stat_full_cyc <= sat_inc(stat_full_cyc,
                               (count == CW'(DEPTH)) && (pend_a || pend_b));
    end
  end
`endif

endmodule

// File: tb/tb_click_sync_merge.sv
// Directed bench for click_sync_merge: latency, merge order, full/back-pressure, round-robin and reset.
module tb_click_sync_merge;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_a_req, in_a_ack, in_b_req, in_b_ack;
  logic [7:0] in_a_data, in_b_data, out_data;
  logic       out_valid, out_ready, out_src;
`ifdef CLICK_SYNC_MERGE_STATS_EN
  logic [15:0] stat_a_cnt, stat_b_cnt, stat_full_cyc;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  click_sync_merge #(.DATA_W(8), .DEPTH(4), .SYNC_STAGES(2),
                     .PHASE_INIT_ACK_A(1'b0), .PHASE_INIT_ACK_B(1'b0)) dut (
    .clk(clk), .rst(rst),
    .in_a_req(in_a_req), .in_a_ack(in_a_ack), .in_a_data(in_a_data),
    .in_b_req(in_b_req), .in_b_ack(in_b_ack), .in_b_data(in_b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
`ifdef CLICK_SYNC_MERGE_STATS_EN
    , .stat_a_cnt(stat_a_cnt), .stat_b_cnt(stat_b_cnt), .stat_full_cyc(stat_full_cyc)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [7:0] d, input logic s);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_src"}, 32'(out_src), 32'(s));
  endtask

  initial begin
    rst = 1'b1; in_a_req = 1'b0; in_b_req = 1'b0;
    in_a_data = 8'h00; in_b_data = 8'h00; out_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_ack_a", 32'(in_a_ack), 32'd0);
    chk("rst_ack_b", 32'(in_b_ack), 32'd0);

    // single A token: ack toggles on the third edge
    in_a_data = 8'h5A; in_a_req = 1'b1;
    tick(2);
    chk("lat_ack_a_early", 32'(in_a_ack), 32'd0);
    chk("lat_valid_early", 32'(out_valid), 32'd0);
    tick(1);
    chk("lat_ack_a", 32'(in_a_ack), 32'd1);
    chk_head("lat_head", 8'h5A, 1'b0);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    chk("lat_drained", 32'(out_valid), 32'd0);

    // simultaneous A and B into an empty FIFO
    in_a_data = 8'h11; in_a_req = 1'b0;
    in_b_data = 8'h22; in_b_req = 1'b1;
    tick(3);
    chk("both_ack_a", 32'(in_a_ack), 32'd0);
    chk("both_ack_b", 32'(in_b_ack), 32'd1);
    chk_head("both_h0", 8'h11, 1'b0);
    out_ready = 1'b1; tick(1);
    chk_head("both_h1", 8'h22, 1'b1);
    tick(1); out_ready = 1'b0;
    chk("both_drained", 32'(out_valid), 32'd0);

    // fill to DEPTH, fifth token held off until a pop
    in_a_data = 8'h31; in_a_req = 1'b1; tick(3);
    in_b_data = 8'h32; in_b_req = 1'b0; tick(3);
    in_a_data = 8'h33; in_a_req = 1'b0; tick(3);
    in_b_data = 8'h34; in_b_req = 1'b1; tick(3);
    chk("full_ack_b4", 32'(in_b_ack), 32'd1);
    in_a_data = 8'h35; in_a_req = 1'b1; tick(5);
    chk("full_ack_a_frozen", 32'(in_a_ack), 32'd0);
    chk_head("full_head", 8'h31, 1'b0);
    out_ready = 1'b1; tick(1);
    chk("full_ack_a_release", 32'(in_a_ack), 32'd1);
    chk_head("full_d0", 8'h32, 1'b1);
    tick(1); chk_head("full_d1", 8'h33, 1'b0);
    tick(1); chk_head("full_d2", 8'h34, 1'b1);
    tick(1); chk_head("full_d3", 8'h35, 1'b0);
    tick(1); out_ready = 1'b0;
    chk("full_count4", 32'(out_valid), 32'd0);

    // round-robin with one free slot: A first, then B
    in_a_data = 8'h41; in_a_req = 1'b0; tick(3);
    in_b_data = 8'h42; in_b_req = 1'b0; tick(3);
    in_a_data = 8'h43; in_a_req = 1'b1; tick(3);
    in_a_data = 8'h44; in_a_req = 1'b0;
    in_b_data = 8'h45; in_b_req = 1'b1;
    tick(3);
    chk("rr1_ack_a", 32'(in_a_ack), 32'd0);
    chk("rr1_ack_b_held", 32'(in_b_ack), 32'd0);
    tick(2);
    chk("rr1_ack_b_still", 32'(in_b_ack), 32'd0);
    out_ready = 1'b1; tick(1);
    chk("rr1_ack_b", 32'(in_b_ack), 32'd1);
    tick(1); out_ready = 1'b0;
    chk_head("rr_mid_head", 8'h43, 1'b0);
    in_a_data = 8'h46; in_a_req = 1'b1;
    in_b_data = 8'h47; in_b_req = 1'b0;
    tick(3);
    chk("rr2_ack_b", 32'(in_b_ack), 32'd0);
    chk("rr2_ack_a_held", 32'(in_a_ack), 32'd0);
    out_ready = 1'b1; tick(1);
    chk("rr2_ack_a", 32'(in_a_ack), 32'd1);
    chk_head("rr_d0", 8'h44, 1'b0);
    tick(1); chk_head("rr_d1", 8'h45, 1'b1);
    tick(1); chk_head("rr_d2", 8'h47, 1'b1);
    tick(1); chk_head("rr_d3", 8'h46, 1'b0);
    tick(1); out_ready = 1'b0;
    chk("rr_drained", 32'(out_valid), 32'd0);

    // reset with two entries queued and B in flight
    in_a_data = 8'h51; in_a_req = 1'b0; tick(3);
    in_b_data = 8'h52; in_b_req = 1'b1; tick(3);
    in_b_data = 8'h53; in_b_req = 1'b0; tick(1);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; tick(1);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ack_a", 32'(in_a_ack), 32'd0);
    chk("mid_rst_ack_b", 32'(in_b_ack), 32'd0);
    in_a_req = 1'b0; in_b_req = 1'b0;
    rst = 1'b0; tick(1);
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    in_a_data = 8'h5C; in_a_req = 1'b1;
    tick(2);
    chk("post_rst_ack_early", 32'(in_a_ack), 32'd0);
    tick(1);
    chk("post_rst_ack_a", 32'(in_a_ack), 32'd1);
    chk_head("post_rst_head", 8'h5C, 1'b0);

`ifdef CLICK_SYNC_MERGE_STATS_EN
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    in_a_data = 8'h61; in_a_req = 1'b0; tick(3);
    in_b_data = 8'h62; in_b_req = 1'b1; tick(3);
    in_a_data = 8'h63; in_a_req = 1'b1; tick(3);
    in_b_data = 8'h64; in_b_req = 1'b0; tick(3);
    chk("stat_a", 32'(stat_a_cnt), 32'd3);
    chk("stat_b", 32'(stat_b_cnt), 32'd2);
    chk("stat_full_zero", 32'(stat_full_cyc), 32'd0);
    in_b_data = 8'h65; in_b_req = 1'b1; tick(12);
    chk("stat_full", 32'(stat_full_cyc), 32'd10);
    chk("stat_b_frozen", 32'(stat_b_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
